// File: rtl/win_addr_gen_if.sv
// rtl/win_addr_gen_if.sv - window address/tap stream between win_addr_gen and its consumer
interface win_addr_gen_if #(
  parameter int ADDR_W = 20,
  parameter int TAP_W  = 4
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [TAP_W-1:0]  tap_idx;
  logic [15:0]       win_x;
  logic [15:0]       win_y;
  logic              win_last;

  modport master (
    output addr_valid, addr, tap_idx, win_x, win_y, win_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, tap_idx, win_x, win_y, win_last,
    output addr_ready
  );
endinterface

// File: rtl/win_addr_gen.sv
// rtl/win_addr_gen.sv - KxK sliding-window pixel address generator for raster frame buffers
module win_addr_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 20
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic           busy,
  output logic           frame_done,
  win_addr_gen_if.master bus
);

  localparam int CW2 = (K * K > 1) ? $clog2(K * K) : 1;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int WX  = (IMG_W - K) / STRIDE + 1;
  localparam int WY  = (IMG_H - K) / STRIDE + 1;

  localparam logic [15:0]       LAST_X  = 16'((WX - 1) * STRIDE);
  localparam logic [15:0]       LAST_Y  = 16'((WY - 1) * STRIDE);
  localparam logic [15:0]       STEP    = 16'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_INC   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] Y_INC   = ADDR_W'(STRIDE * IMG_W);
  localparam logic [CW-1:0]     K_LAST  = CW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     kr, kc;
  logic [CW2-1:0]    tap;
  logic [15:0]       wx, wy;
  logic [ADDR_W-1:0] addr_q;
  // Address of the current tap row, the current window origin and the origin row's column 0.
  logic [ADDR_W-1:0] row_base, win_base, line_base;

  logic accept, tap_end, win_end, row_end, frame_end;

  assign accept    = (state == S_RUN) && bus.addr_ready;
  assign tap_end   = (kc == K_LAST);
  assign win_end   = tap_end && (kr == K_LAST);
  assign row_end   = (wx == LAST_X);
  assign frame_end = win_end && row_end && (wy == LAST_Y);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && frame_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath only moves on an accepted beat, so a stalled beat holds every field.
  always_ff @(posedge clk) begin
    if (!reset_n || ((state == S_IDLE) && start) || (accept && frame_end)) begin
      kr        <= '0;
      kc        <= '0;
      tap       <= '0;
      wx        <= '0;
      wy        <= '0;
      addr_q    <= '0;
      row_base  <= '0;
      win_base  <= '0;
      line_base <= '0;
    end else if (accept) begin
      if (!tap_end) begin
        kc     <= kc + 1'b1;
        tap    <= tap + 1'b1;
        addr_q <= addr_q + 1'b1;
      end else if (!win_end) begin
        kc       <= '0;
        kr       <= kr + 1'b1;
        tap      <= tap + 1'b1;
        row_base <= row_base + ROW_INC;
        addr_q   <= row_base + ROW_INC;
      end else begin
        kc  <= '0;
        kr  <= '0;
        tap <= '0;
        if (!row_end) begin
          wx       <= wx + STEP;
          win_base <= win_base + X_INC;
          row_base <= win_base + X_INC;
          addr_q   <= win_base + X_INC;
        end else begin
          wx        <= '0;
          wy        <= wy + STEP;
          line_base <= line_base + Y_INC;
          win_base  <= line_base + Y_INC;
          row_base  <= line_base + Y_INC;
          addr_q    <= line_base + Y_INC;
        end
      end
    end
  end

  assign bus.addr_valid = (state == S_RUN);
  assign bus.addr       = addr_q;
  assign bus.tap_idx    = tap;
  assign bus.win_x      = wx;
  assign bus.win_y      = wy;
  assign bus.win_last   = win_end && (state == S_RUN);
  assign busy           = (state == S_RUN);
  assign frame_done     = (state == S_DONE);

endmodule

// File: tb/tb_win_addr_gen.sv
// tb/tb_win_addr_gen.sv - scoreboard bench for win_addr_gen across three parameter sets
module tb_win_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic busy0, busy1, busy2, fd0, fd1, fd2;

  win_addr_gen_if #(.ADDR_W(20), .TAP_W(4)) bus0 ();
  win_addr_gen_if #(.ADDR_W(20), .TAP_W(4)) bus1 ();
  win_addr_gen_if #(.ADDR_W(20), .TAP_W(1)) bus2 ();

  assign bus0.addr_ready = rdy0;
  assign bus1.addr_ready = rdy1;
  assign bus2.addr_ready = rdy2;

  win_addr_gen #(.IMG_W(8), .IMG_H(6), .K(3), .STRIDE(1), .ADDR_W(20)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .frame_done(fd0), .bus(bus0.master));
  win_addr_gen #(.IMG_W(8), .IMG_H(6), .K(3), .STRIDE(2), .ADDR_W(20)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .frame_done(fd1), .bus(bus1.master));
  win_addr_gen #(.IMG_W(4), .IMG_H(2), .K(1), .STRIDE(1), .ADDR_W(20)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .frame_done(fd2), .bus(bus2.master));

  typedef struct packed {
    logic [19:0] a;
    logic [3:0]  t;
    logic [15:0] x;
    logic [15:0] y;
    logic        l;
    logic        f;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   log0[$], log1[$], log2[$];
  int   n_cmp = 0, n_bad = 0;
  int   n_acc[3];
  bit   fin_pend[3];
  bit   hold[3];
  logic [56:0] snap[3];

  task automatic chk(input string nm, input int sel, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, sel, act, exp);
    end
  endtask

  task automatic push_frame(input int sel, input int w, input int h, input int k, input int s);
    int nx, ny;
    exp_t e;
    nx = (w - k) / s + 1;
    ny = (h - k) / s + 1;
    for (int oy = 0; oy < ny; oy++)
      for (int ox = 0; ox < nx; ox++)
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++) begin
            e.a = 20'((oy * s + r) * w + ox * s + c);
            e.t = 4'(r * k + c);
            e.x = 16'(ox * s);
            e.y = 16'(oy * s);
            e.l = (r == k - 1) && (c == k - 1);
            e.f = e.l && (ox == nx - 1) && (oy == ny - 1);
            case (sel)
              0: q0.push_back(e);
              1: q1.push_back(e);
              default: q2.push_back(e);
            endcase
          end
  endtask

  task automatic pop_exp(input int sel, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (sel)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic mon(input int sel, input logic v, input logic r, input logic [19:0] a,
                     input logic [3:0] t, input logic [15:0] x, input logic [15:0] y,
                     input logic l, input logic b, input logic fd);
    logic [56:0] cur;
    exp_t e;
    bit ok;
    cur = {a, t, x, y, l};
    if (!reset_n) begin
      hold[sel]     = 1'b0;
      fin_pend[sel] = 1'b0;
      return;
    end
    if (hold[sel]) begin
      chk("hold_fields", sel, 64'(cur), 64'(snap[sel]));
      chk("hold_valid", sel, 64'(v), 64'd1);
    end
    hold[sel] = v && !r;
    snap[sel] = cur;
    if (fin_pend[sel] || fd) begin
      chk("frame_done", sel, 64'(fd), 64'(fin_pend[sel]));
      if (fin_pend[sel]) begin
        chk("done_busy", sel, 64'(b), 64'd0);
        chk("done_valid", sel, 64'(v), 64'd0);
      end
    end
    fin_pend[sel] = 1'b0;
    if (v && r) begin
      pop_exp(sel, ok, e);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL unexpected_beat dut%0d: got addr %0d expected no beat", sel, a);
      end else begin
        chk("addr", sel, 64'(a), 64'(e.a));
        chk("tap_idx", sel, 64'(t), 64'(e.t));
        chk("win_x", sel, 64'(x), 64'(e.x));
        chk("win_y", sel, 64'(y), 64'(e.y));
        chk("win_last", sel, 64'(l), 64'(e.l));
        fin_pend[sel] = e.f;
      end
      n_acc[sel]++;
      case (sel)
        0: log0.push_back(int'(a));
        1: log1.push_back(int'(a));
        default: log2.push_back(int'(a));
      endcase
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.addr_valid, bus0.addr_ready, bus0.addr, bus0.tap_idx, bus0.win_x, bus0.win_y,
        bus0.win_last, busy0, fd0);
    mon(1, bus1.addr_valid, bus1.addr_ready, bus1.addr, bus1.tap_idx, bus1.win_x, bus1.win_y,
        bus1.win_last, busy1, fd1);
    mon(2, bus2.addr_valid, bus2.addr_ready, bus2.addr, {3'b000, bus2.tap_idx}, bus2.win_x,
        bus2.win_y, bus2.win_last, busy2, fd2);
  end

  function automatic logic fdv(input int sel);
    case (sel)
      0: return fd0;
      1: return fd1;
      default: return fd2;
    endcase
  endfunction

  task automatic wait_done(input int sel, input int budget, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rnd) rdy0 = 1'($urandom_range(0, 1));
      @(negedge clk);
      seen = fdv(sel);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL frame_done_timeout dut%0d: got no pulse expected pulse within %0d cycles", sel, budget);
    end
  endtask

  task automatic pulse_start0;
    @(posedge clk); #1 start0 = 1'b1;
    @(negedge clk);
    chk("pre_start_valid", 0, 64'(bus0.addr_valid), 64'd0);
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    chk("start_latency_valid", 0, 64'(bus0.addr_valid), 64'd1);
    chk("start_busy", 0, 64'(busy0), 64'd1);
  endtask

  task automatic check_idle0(input string nm);
    chk({nm, "_valid"}, 0, 64'(bus0.addr_valid), 64'd0);
    chk({nm, "_addr"}, 0, 64'(bus0.addr), 64'd0);
    chk({nm, "_tap"}, 0, 64'(bus0.tap_idx), 64'd0);
    chk({nm, "_winx"}, 0, 64'(bus0.win_x), 64'd0);
    chk({nm, "_winy"}, 0, 64'(bus0.win_y), 64'd0);
    chk({nm, "_last"}, 0, 64'(bus0.win_last), 64'd0);
    chk({nm, "_busy"}, 0, 64'(busy0), 64'd0);
    chk({nm, "_done"}, 0, 64'(fd0), 64'd0);
  endtask

  int t1_addr[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_acc[i] = 0; fin_pend[i] = 1'b0; hold[i] = 1'b0; snap[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle0("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // T1/T2: full frame, ready held high
    rdy0 = 1'b1;
    push_frame(0, 8, 6, 3, 1);
    pulse_start0();
    wait_done(0, 1000, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 0, 64'(fd0), 64'd0);
    chk("t2_beats", 0, 64'(log0.size()), 64'd216);
    for (int i = 0; i < 9; i++) chk("t1_addr", 0, 64'(log0[i]), 64'(t1_addr[i]));
    chk("t1_win2_first", 0, 64'(log0[9]), 64'd1);
    chk("t2_win7_first", 0, 64'(log0[54]), 64'd8);
    chk("t2_last_addr", 0, 64'(log0[215]), 64'd47);
    chk("t2_queue_empty", 0, 64'(q0.size()), 64'd0);

    // T4: random backpressure, same accepted sequence
    log0.delete();
    push_frame(0, 8, 6, 3, 1);
    pulse_start0();
    wait_done(0, 3000, 1'b1);
    rdy0 = 1'b1;
    chk("t4_beats", 0, 64'(log0.size()), 64'd216);
    chk("t4_last_addr", 0, 64'(log0[215]), 64'd47);

    // T5: start during RUN ignored, then reset mid-frame
    log0.delete();
    n_acc[0] = 0;
    push_frame(0, 8, 6, 3, 1);
    pulse_start0();
    for (int i = 0; i < 500 && n_acc[0] < 10; i++) @(negedge clk);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 500 && n_acc[0] < 40; i++) @(negedge clk);
    chk("t5_reached_beat40", 0, 64'(n_acc[0] >= 40), 64'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_idle0("midreset");
    q0.delete();
    repeat (5) begin
      @(negedge clk);
      chk("no_frame_done_after_reset", 0, 64'(fd0), 64'd0);
      chk("no_restart_after_reset", 0, 64'(bus0.addr_valid), 64'd0);
    end
    log0.delete();
    push_frame(0, 8, 6, 3, 1);
    pulse_start0();
    wait_done(0, 1000, 1'b0);
    chk("t5_restart_addr0", 0, 64'(log0[0]), 64'd0);
    chk("t5_restart_beats", 0, 64'(log0.size()), 64'd216);

    // T3: STRIDE=2 with start held through DONE into the following IDLE
    rdy1 = 1'b1;
    push_frame(1, 8, 6, 3, 2);
    push_frame(1, 8, 6, 3, 2);
    @(posedge clk); #1 start1 = 1'b1;
    wait_done(1, 1000, 1'b0);
    @(negedge clk);
    chk("t3_done_ignores_start", 1, 64'(bus1.addr_valid), 64'd0);
    chk("t3_idle_busy", 1, 64'(busy1), 64'd0);
    @(negedge clk);
    chk("t3_idle_restart_valid", 1, 64'(bus1.addr_valid), 64'd1);
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(1, 1000, 1'b0);
    chk("t3_beats", 1, 64'(log1.size()), 64'd108);
    chk("t3_win2_first", 1, 64'(log1[9]), 64'd2);
    chk("t3_lastwin_first", 1, 64'(log1[45]), 64'd20);
    chk("t3_last_addr", 1, 64'(log1[53]), 64'd38);
    chk("t3_frame2_first", 1, 64'(log1[54]), 64'd0);
    chk("t3_queue_empty", 1, 64'(q1.size()), 64'd0);

    // T6: K=1 degenerate window
    rdy2 = 1'b1;
    push_frame(2, 4, 2, 1, 1);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    wait_done(2, 100, 1'b0);
    chk("t6_beats", 2, 64'(log2.size()), 64'd8);
    chk("t6_last_addr", 2, 64'(log2[7]), 64'd7);
    chk("t6_queue_empty", 2, 64'(q2.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
